// File: rtl/decode_redirect_if.sv
// Fetch/decode boundary signal bundle. The master side (fetch, register file,
// hazard unit) drives the stage inputs; the slave side is the decode stage.
interface decode_redirect_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instruction_f;
  logic [31:0]      pc_plus_4_f;
  logic             stall_d;
  logic [31:0]      rd1_d;
  logic [31:0]      rd2_d;
  logic [31:0]      alu_out_m;
  logic             forward_a_d;
  logic             forward_b_d;
  logic [31:0]      instr_d;
  logic [31:0]      pc_plus_4_d;
  logic             valid_d;
  logic [31:0]      pc_branch_d;
  logic             pc_src_d;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output instruction_f, pc_plus_4_f, stall_d, rd1_d, rd2_d, alu_out_m,
           forward_a_d, forward_b_d,
    input  instr_d, pc_plus_4_d, valid_d, pc_branch_d, pc_src_d, redirect_count
  );

  modport slave (
    input  instruction_f, pc_plus_4_f, stall_d, rd1_d, rd2_d, alu_out_m,
           forward_a_d, forward_b_d,
    output instr_d, pc_plus_4_d, valid_d, pc_branch_d, pc_src_d, redirect_count
  );
endinterface

// File: rtl/decode_redirect.sv
// Decode stage of the pipelined MIPS core: IF/ID register with stall/flush,
// early branch/jump resolution with redirect to fetch, and a saturating
// redirect counter.
module decode_redirect #(
  parameter int unsigned CNT_W = 16
) (
  input logic              clock,
  input logic              reset_n,
  decode_redirect_if.slave bus
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] src_a, src_b;
  logic        eq;
  logic [5:0]  op, funct;
  logic        is_beq, is_bne, is_j, is_jal, is_jr;
  logic        taken;
  logic        pc_src;
  logic [31:0] imm_off;
  logic [31:0] pc_branch;

  // Operand forwarding, decode and redirect target
  always_comb begin
    src_a   = bus.forward_a_d ? bus.alu_out_m : bus.rd1_d;
    src_b   = bus.forward_b_d ? bus.alu_out_m : bus.rd2_d;
    eq      = (src_a == src_b);
    op      = instr_q[31:26];
    funct   = instr_q[5:0];
    is_beq  = (op == 6'b000100);
    is_bne  = (op == 6'b000101);
    is_j    = (op == 6'b000010);
    is_jal  = (op == 6'b000011);
    is_jr   = (op == 6'b000000) && (funct == 6'b001000);
    taken   = (is_beq & eq) | (is_bne & ~eq) | is_j | is_jal | is_jr;
    // A stalled branch must not redirect; it is re-evaluated once released
    pc_src  = valid_q & ~bus.stall_d & taken;
    imm_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (is_j || is_jal) begin
      pc_branch = {pc4_q[31:28], instr_q[25:0], 2'b00};
    end else if (is_jr) begin
      pc_branch = src_a;
    end else begin
      pc_branch = pc4_q + imm_off;
    end
  end

  // IF/ID next state: stall holds, redirect squashes the fall-through, else load
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (!bus.stall_d) begin
      pc4_d = bus.pc_plus_4_f;
      if (pc_src) begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end else begin
        instr_d = bus.instruction_f;
        valid_d = 1'b1;
      end
    end
    if (pc_src && (count_q != CntMax)) begin
      count_d = count_q + CntOne;
    end
  end

  // Pipeline and counter state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.instr_d        = instr_q;
  assign bus.pc_plus_4_d    = pc4_q;
  assign bus.valid_d        = valid_q;
  assign bus.pc_branch_d    = pc_branch;
  assign bus.pc_src_d       = pc_src;
  assign bus.redirect_count = count_q;

endmodule

// File: tb/tb_decode_redirect.sv
// Self-checking bench for decode_redirect: table of decode vectors plus
// hand-written stall, flush, saturation and asynchronous reset sequences.
module tb_decode_redirect;

  logic clock;
  logic reset_n;

  decode_redirect_if #(.CNT_W(16)) bus ();
  decode_redirect_if #(.CNT_W(4))  sbus ();

  decode_redirect #(.CNT_W(16)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Narrow-counter copy sharing the same stimulus, to reach saturation quickly
  decode_redirect #(.CNT_W(4)) u_dut_small (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sbus)
  );

  assign sbus.instruction_f = bus.instruction_f;
  assign sbus.pc_plus_4_f   = bus.pc_plus_4_f;
  assign sbus.stall_d       = bus.stall_d;
  assign sbus.rd1_d         = bus.rd1_d;
  assign sbus.rd2_d         = bus.rd2_d;
  assign sbus.alu_out_m     = bus.alu_out_m;
  assign sbus.forward_a_d   = bus.forward_a_d;
  assign sbus.forward_b_d   = bus.forward_b_d;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu;
    logic        fa;
    logic        fb;
    logic        exp_src;
    logic [31:0] exp_br;
  } vec_t;

  localparam int NumVec = 16;
  vec_t vecs [NumVec];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Clear the stage with a short reset pulse, then load one instruction
  task automatic load(input logic [31:0] instr, input logic [31:0] pc4);
    @(negedge clock);
    reset_n         = 1'b0;
    bus.stall_d     = 1'b0;
    bus.forward_a_d = 1'b0;
    bus.forward_b_d = 1'b0;
    #1;
    reset_n           = 1'b1;
    bus.instruction_f = instr;
    bus.pc_plus_4_f   = pc4;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //            instr         pc4           rd1           rd2           alu        fa    fb    src   target
    vecs[0]  = '{32'h20080005, 32'h00400004, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 1'b0, 32'h00400018};
    vecs[1]  = '{32'h1109FFFE, 32'h00400010, 32'h7,       32'h7,       32'h0,       1'b0, 1'b0, 1'b1, 32'h00400008};
    vecs[2]  = '{32'h1109FFFE, 32'h00400010, 32'h7,       32'h8,       32'h0,       1'b0, 1'b0, 1'b0, 32'h00400008};
    vecs[3]  = '{32'h15090003, 32'h00400020, 32'h5,       32'h5,       32'h6,       1'b1, 1'b0, 1'b1, 32'h0040002C};
    vecs[4]  = '{32'h15090003, 32'h00400020, 32'h5,       32'h5,       32'h6,       1'b0, 1'b0, 1'b0, 32'h0040002C};
    vecs[5]  = '{32'h15090003, 32'h00400020, 32'h6,       32'h5,       32'h6,       1'b0, 1'b1, 1'b0, 32'h0040002C};
    vecs[6]  = '{32'h1109FFFE, 32'h00400010, 32'h1,       32'h2,       32'h9,       1'b1, 1'b1, 1'b1, 32'h00400008};
    vecs[7]  = '{32'h08100000, 32'h00400100, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 1'b1, 32'h00400000};
    vecs[8]  = '{32'h08000010, 32'hF0000004, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 1'b1, 32'hF0000040};
    vecs[9]  = '{32'h0C100004, 32'h00400000, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 1'b1, 32'h00400010};
    vecs[10] = '{32'h03E00008, 32'h00400200, 32'h00400040, 32'h0,       32'h0,       1'b0, 1'b0, 1'b1, 32'h00400040};
    vecs[11] = '{32'h03E00008, 32'h00400200, 32'h00400040, 32'h0,       32'h00400080, 1'b1, 1'b0, 1'b1, 32'h00400080};
    vecs[12] = '{32'h01095020, 32'h00400000, 32'h3,       32'h3,       32'h0,       1'b0, 1'b0, 1'b0, 32'h00414080};
    vecs[13] = '{32'h10008000, 32'h00010000, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 1'b1, 32'hFFFF0000};
    vecs[14] = '{32'h10007FFF, 32'hFFFFFFF0, 32'h3,       32'h3,       32'h0,       1'b0, 1'b0, 1'b1, 32'h0001FFEC};
    vecs[15] = '{32'h1C000004, 32'h00400000, 32'h1,       32'h1,       32'h0,       1'b0, 1'b0, 1'b0, 32'h00400010};

    reset_n           = 1'b0;
    bus.instruction_f = 32'h0;
    bus.pc_plus_4_f   = 32'h0;
    bus.stall_d       = 1'b0;
    bus.rd1_d         = 32'h0;
    bus.rd2_d         = 32'h0;
    bus.alu_out_m     = 32'h0;
    bus.forward_a_d   = 1'b0;
    bus.forward_b_d   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset instr_d", bus.instr_d, 32'h0);
    check("reset pc_plus_4_d", bus.pc_plus_4_d, 32'h0);
    check("reset valid_d", 32'(bus.valid_d), 32'h0);
    check("reset pc_src_d", 32'(bus.pc_src_d), 32'h0);
    check("reset count", 32'(bus.redirect_count), 32'h0);

    // Table-driven decode vectors
    for (int i = 0; i < NumVec; i++) begin
      load(vecs[i].instr, vecs[i].pc4);
      bus.rd1_d       = vecs[i].rd1;
      bus.rd2_d       = vecs[i].rd2;
      bus.alu_out_m   = vecs[i].alu;
      bus.forward_a_d = vecs[i].fa;
      bus.forward_b_d = vecs[i].fb;
      #1;
      check($sformatf("vec%0d instr_d", i), bus.instr_d, vecs[i].instr);
      check($sformatf("vec%0d pc_plus_4_d", i), bus.pc_plus_4_d, vecs[i].pc4);
      check($sformatf("vec%0d valid_d", i), 32'(bus.valid_d), 32'h1);
      check($sformatf("vec%0d pc_src_d", i), 32'(bus.pc_src_d), 32'(vecs[i].exp_src));
      check($sformatf("vec%0d pc_branch_d", i), bus.pc_branch_d, vecs[i].exp_br);
    end

    // Taken beq held by stall for 3 edges, then released and flushed
    load(32'h1109FFFE, 32'h00400010);
    bus.rd1_d = 32'h7;
    bus.rd2_d = 32'h7;
    #1;
    check("pre-stall pc_src_d", 32'(bus.pc_src_d), 32'h1);
    @(negedge clock);
    bus.stall_d       = 1'b1;
    bus.instruction_f = 32'h20080005;
    bus.pc_plus_4_f   = 32'h00400014;
    #1;
    check("stall pc_src_d", 32'(bus.pc_src_d), 32'h0);
    repeat (3) @(posedge clock);
    #1;
    check("stall instr_d", bus.instr_d, 32'h1109FFFE);
    check("stall pc_plus_4_d", bus.pc_plus_4_d, 32'h00400010);
    check("stall valid_d", 32'(bus.valid_d), 32'h1);
    check("stall count", 32'(bus.redirect_count), 32'h0);
    check("stall hold pc_src_d", 32'(bus.pc_src_d), 32'h0);
    @(negedge clock);
    bus.stall_d = 1'b0;
    #1;
    check("release pc_src_d", 32'(bus.pc_src_d), 32'h1);
    check("release pc_branch_d", bus.pc_branch_d, 32'h00400008);
    @(posedge clock);
    #1;
    check("flush instr_d", bus.instr_d, 32'h0);
    check("flush valid_d", 32'(bus.valid_d), 32'h0);
    check("flush pc_plus_4_d", bus.pc_plus_4_d, 32'h00400014);
    check("flush count", 32'(bus.redirect_count), 32'h1);
    check("flush pc_src_d", 32'(bus.pc_src_d), 32'h0);
    @(posedge clock);
    #1;
    check("post-flush load instr_d", bus.instr_d, 32'h20080005);
    check("post-flush load valid_d", 32'(bus.valid_d), 32'h1);

    // Back-to-back jumps: one redirect every two edges
    load(32'h08100000, 32'h00400100);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    check("15 redirects count16", 32'(bus.redirect_count), 32'd15);
    check("15 redirects count4", 32'(sbus.redirect_count), 32'hF);
    repeat (10) @(posedge clock);
    #1;
    check("20 redirects count16", 32'(bus.redirect_count), 32'd20);
    check("saturated count4", 32'(sbus.redirect_count), 32'hF);

    // Asynchronous reset in the middle of a cycle, no clock edge needed
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async reset instr_d", bus.instr_d, 32'h0);
    check("async reset valid_d", 32'(bus.valid_d), 32'h0);
    check("async reset pc_src_d", 32'(bus.pc_src_d), 32'h0);
    check("async reset count16", 32'(bus.redirect_count), 32'h0);
    check("async reset count4", 32'(sbus.redirect_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
